// File: rtl/csa_stream_accumulator.sv
`timescale 1ns/1ps
// Purpose: signed add/sub stream accumulator; carry-save running total, chunked carry-propagate resolve on last.
// Latency: one cycle per operand; result valid ACC_W/CHUNK_W cycles after the edge accepting the last operand.
// Backpressure: in_ready low while resolving or holding a result; result held stable until out_ready.
// Optional: define CSA_ACC_SAT_EN to saturate out_data to the 32-bit signed range on overflow.
module csa_stream_accumulator #(
  parameter int ACC_W   = 40,  // > 32: 32 data bits plus guard bits
  parameter int CHUNK_W = 8    // must divide ACC_W
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_in_data,
  input  logic        i_in_sub,
  input  logic        i_in_last,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_data,
  output logic        o_out_of
);

  localparam int N     = ACC_W / CHUNK_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [ACC_W-1:0]   r_sum;
  logic [ACC_W-1:0]   r_carry;
  logic [ACC_W-1:0]   r_res;
  logic [CNT_W-1:0]   r_k;
  logic               r_cc;

  logic               w_accept;
  logic [ACC_W-1:0]   w_x_ext;
  logic [ACC_W-1:0]   w_x;
  logic [ACC_W-1:0]   w_sum_nxt;
  logic [ACC_W-1:0]   w_maj;
  logic [ACC_W-1:0]   w_carry_nxt;
  logic [CHUNK_W-1:0] w_s_chunk;
  logic [CHUNK_W-1:0] w_c_chunk;
  logic [CHUNK_W:0]   w_chunk_add;
  logic [ACC_W-32:0]  w_top;
  logic               w_of;

  // Operand conditioning and one 3:2 compressor layer. For subtract the
  // operand is inverted and the +1 rides in carry bit 0, which the left
  // shift of the majority vector always leaves free.
  always_comb begin
    w_accept    = i_in_valid & o_in_ready;
    w_x_ext     = {{(ACC_W-32){i_in_data[31]}}, i_in_data};
    w_x         = i_in_sub ? ~w_x_ext : w_x_ext;
    w_sum_nxt   = r_sum ^ r_carry ^ w_x;
    w_maj       = (r_sum & r_carry) | (r_sum & w_x) | (r_carry & w_x);
    w_carry_nxt = {w_maj[ACC_W-2:0], i_in_sub};
  end

  // One chunk of the carry-propagate pass; top-chunk carry-out is dropped.
  always_comb begin
    w_s_chunk   = r_sum[r_k*CHUNK_W +: CHUNK_W];
    w_c_chunk   = r_carry[r_k*CHUNK_W +: CHUNK_W];
    w_chunk_add = {1'b0, w_s_chunk} + {1'b0, w_c_chunk} + {{CHUNK_W{1'b0}}, r_cc};
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        o_in_ready = 1'b1;
        if (i_in_valid && i_in_last) begin
          w_state_nxt = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        if (r_k == CNT_W'(N-1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_nxt = ST_ACCUM;
        end
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  // Accumulator, resolver and result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum   <= '0;
      r_carry <= '0;
      r_res   <= '0;
      r_k     <= '0;
      r_cc    <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_sum   <= w_sum_nxt;
            r_carry <= w_carry_nxt;
            if (i_in_last) begin
              r_k   <= '0;
              r_res <= '0;
              r_cc  <= 1'b0;
            end
          end
        end
        ST_RESOLVE: begin
          r_res[r_k*CHUNK_W +: CHUNK_W] <= w_chunk_add[CHUNK_W-1:0];
          r_cc                          <= w_chunk_add[CHUNK_W];
          r_k                           <= r_k + 1'b1;
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_sum   <= '0;
            r_carry <= '0;
          end
        end
        default: begin
          r_sum   <= '0;
          r_carry <= '0;
        end
      endcase
    end
  end

  // Overflow when the guard bits plus bit 31 are not a pure sign extension.
  always_comb begin
    w_top    = r_res[ACC_W-1:31];
    w_of     = ~((&w_top) | ~(|w_top));
    o_out_of = w_of;
`ifdef CSA_ACC_SAT_EN
    if (w_of) begin
      o_out_data = r_res[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      o_out_data = r_res[31:0];
    end
`else
    o_out_data = r_res[31:0];
`endif
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
`timescale 1ns/1ps
// Bench for csa_stream_accumulator: directed cases plus random streams
// checked against an integer running-total model.
module tb_csa_stream_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sub;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_of;

  int     total_cnt = 0;
  int     bad_cnt   = 0;
  longint acc_model = 0;

  always #5 clk = ~clk;

  csa_stream_accumulator #(.ACC_W(40), .CHUNK_W(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .i_in_sub    (in_sub),
    .i_in_last   (in_last),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_of    (out_of)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_data"},  64'(out_data),  64'd0);
    check({tag, "_out_of"},    64'(out_of),    64'd0);
  endtask

  // Present one operand; it is accepted on the following rising edge.
  task automatic send(input logic [31:0] d, input logic s, input logic l);
    longint v;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    in_last  = l;
    check("in_ready_accum", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    v = longint'($signed(d));
    acc_model = s ? acc_model - v : acc_model + v;
  endtask

  // Wait for the result, compare against the model, hold it for 'hold'
  // cycles with an ignored in_valid pulse, then consume it.
  task automatic expect_result(input bit chk_lat, input int hold);
    longint      r;
    logic [31:0] ed;
    logic        eo;
    int          cyc;
    r  = (acc_model <<< 24) >>> 24;
    eo = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    ed = r[31:0];
`ifdef CSA_ACC_SAT_EN
    if (eo) ed = (r < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    cyc = 0;
    while (cyc < 30 && out_valid !== 1'b1) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("out_valid_rise", 64'(out_valid), 64'd1);
    if (chk_lat) check("latency", 64'(cyc), 64'd5);
    check("out_data", 64'(out_data), 64'(ed));
    check("out_of",   64'(out_of),   64'(eo));
    check("in_ready_done", 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = (i == 1);
      in_data  = 32'd99;
      in_last  = 1'b1;
      check("hold_valid",    64'(out_valid), 64'd1);
      check("hold_data",     64'(out_data),  64'(ed));
      check("hold_of",       64'(out_of),    64'(eo));
      check("hold_in_ready", 64'(in_ready),  64'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("after_hs_valid", 64'(out_valid), 64'd0);
    check("after_hs_ready", 64'(in_ready),  64'd1);
    acc_model = 0;
  endtask

  initial begin
    int          n;
    logic [31:0] d;
    logic        s;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sub    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset values during and after reset.
    #12;
    check_idle("rst_low");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("rst_rel");

    // out_ready while idle is ignored.
    out_ready = 1'b1;
    @(negedge clk);
    check("idle_out_ready_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Single operand.
    send(32'd5, 1'b0, 1'b1);
    expect_result(1'b1, 0);

    // Mixed add/sub.
    send(32'd100, 1'b0, 1'b0);
    send(32'd30,  1'b1, 1'b0);
    send(32'd70,  1'b1, 1'b1);
    expect_result(1'b1, 0);

    send(32'd3,          1'b0, 1'b0);
    send(32'hFFFF_FFF9,  1'b0, 1'b0);
    send(32'd10,         1'b0, 1'b1);
    expect_result(1'b1, 0);

    // Overflow both directions.
    send(32'h7FFF_FFFF, 1'b0, 1'b0);
    send(32'd1,         1'b0, 1'b1);
    expect_result(1'b1, 0);

    send(32'h8000_0000, 1'b0, 1'b0);
    send(32'd1,         1'b1, 1'b1);
    expect_result(1'b1, 0);

    // Back-pressure, then confirm the accumulator cleared.
    send(32'd42, 1'b0, 1'b1);
    expect_result(1'b1, 3);
    send(32'd7, 1'b0, 1'b1);
    expect_result(1'b1, 0);

    // Reset during RESOLVE.
    send(32'd1, 1'b0, 1'b0);
    send(32'd2, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("rst_resolve");
    acc_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_valid_after_rst", 64'(out_valid), 64'd0);
    end
    send(32'd1, 1'b0, 1'b1);
    expect_result(1'b1, 0);

    // Reset mid-stream in ACCUM discards the partial sum.
    send(32'd123, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("rst_accum");
    acc_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send(32'd4, 1'b0, 1'b1);
    expect_result(1'b1, 0);

    // Random streams.
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        d = $urandom;
        if ($urandom_range(0, 1) == 1) d = $urandom_range(0, 200);
        s = 1'($urandom_range(0, 1));
        send(d, s, (j == n - 1));
      end
      expect_result(1'b1, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
